dcache_control: RTL

Sequencing controller for the two-way set-associative L1 data cache datapath (`dcache_datapath`). It accepts CPU-side read/write requests, resolves hits in the request cycle, and on a miss runs a write-back/allocate sequence against L2. It drives every array write enable, the LRU/dirty/valid update values and the datapath mux selects, and keeps saturating hit/miss/write-back counters. It sits between the MEM pipeline stage, `dcache_datapath` and the L2 port.

---
 rtl/lc3b_types.sv | 13 +
 rtl/sat_counter.sv | 24 ++
 rtl/dcache_control.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } lc3b_dcache_state;

    // lru_dataout value that names way A as the victim.
    localparam logic LRU_VICTIM_A = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dcache_control.sv
// Two-way set-associative L1 data cache controller: hit handling, write-back and
// allocate sequencing against L2, plus hit/miss/write-back counters.
module dcache_control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dcache_read,
    input  logic                 dcache_write,
    output logic                 dcache_resp,
    input  logic                 hit_A,
    input  logic                 hit_B,
    input  logic                 valid_A_dataout,
    input  logic                 valid_B_dataout,
    input  logic                 dirty_A_dataout,
    input  logic                 dirty_B_dataout,
    input  logic                 lru_dataout,
    output logic                 valid_A_write,
    output logic                 valid_B_write,
    output logic                 dirty_A_write,
    output logic                 dirty_B_write,
    output logic                 tag_A_write,
    output logic                 tag_B_write,
    output logic                 data_A_write_ctrl,
    output logic                 data_B_write_ctrl,
    output logic                 lru_write,
    output logic                 valid_A_datain,
    output logic                 valid_B_datain,
    output logic                 dirty_A_datain,
    output logic                 dirty_B_datain,
    output logic                 lru_datain,
    output logic                 pmemaddressmux_sel,
    output logic                 replacemux_sel,
    output logic                 L2_read,
    output logic                 L2_write,
    input  logic                 L2_resp,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    lc3b_dcache_state r_state;
    lc3b_dcache_state w_next_state;

    logic w_req;
    logic w_hit;
    logic w_victim_a;
    logic w_victim_dirty;
    logic w_hit_inc;
    logic w_miss_inc;
    logic w_wb_inc;
    logic [CNT_WIDTH-1:0] w_hit_cnt;
    logic [CNT_WIDTH-1:0] w_miss_cnt;
    logic [CNT_WIDTH-1:0] w_wb_cnt;

    assign w_req          = dcache_read | dcache_write;
    assign w_hit          = hit_A | hit_B;
    assign w_victim_a     = (lru_dataout == LRU_VICTIM_A);
    assign w_victim_dirty = w_victim_a ? (valid_A_dataout & dirty_A_dataout)
                                       : (valid_B_dataout & dirty_B_dataout);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_next_state       = r_state;
        dcache_resp        = 1'b0;
        valid_A_write      = 1'b0;
        valid_B_write      = 1'b0;
        dirty_A_write      = 1'b0;
        dirty_B_write      = 1'b0;
        tag_A_write        = 1'b0;
        tag_B_write        = 1'b0;
        data_A_write_ctrl  = 1'b0;
        data_B_write_ctrl  = 1'b0;
        lru_write          = 1'b0;
        valid_A_datain     = 1'b0;
        valid_B_datain     = 1'b0;
        dirty_A_datain     = 1'b0;
        dirty_B_datain     = 1'b0;
        lru_datain         = 1'b0;
        pmemaddressmux_sel = 1'b0;
        replacemux_sel     = 1'b0;
        L2_read            = 1'b0;
        L2_write           = 1'b0;
        w_hit_inc          = 1'b0;
        w_miss_inc         = 1'b0;
        w_wb_inc           = 1'b0;

        if (reset) begin
            w_next_state = IDLE;
        end else begin
            replacemux_sel = 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (w_req && w_hit) begin
                        dcache_resp = 1'b1;
                        lru_write   = 1'b1;
                        lru_datain  = !hit_A;
                        w_hit_inc   = 1'b1;
                        if (dcache_write) begin
                            dirty_A_write  = hit_A;
                            dirty_A_datain = hit_A;
                            dirty_B_write  = !hit_A;
                            dirty_B_datain = !hit_A;
                        end
                    end else if (w_req) begin
                        w_miss_inc   = 1'b1;
                        w_next_state = w_victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    L2_write           = 1'b1;
                    pmemaddressmux_sel = 1'b1;
                    if (L2_resp) begin
                        w_wb_inc     = 1'b1;
                        w_next_state = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    L2_read        = 1'b1;
                    replacemux_sel = 1'b0;
                    if (L2_resp) begin
                        // Refill the victim way: new line, valid and clean.
                        data_A_write_ctrl = w_victim_a;
                        tag_A_write       = w_victim_a;
                        valid_A_write     = w_victim_a;
                        valid_A_datain    = 1'b1;
                        dirty_A_write     = w_victim_a;
                        data_B_write_ctrl = !w_victim_a;
                        tag_B_write       = !w_victim_a;
                        valid_B_write     = !w_victim_a;
                        valid_B_datain    = 1'b1;
                        dirty_B_write     = !w_victim_a;
                        w_next_state      = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // NOTE: only the counters clear on reset; the metadata arrays live in the datapath and keep their contents.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_hit_inc),
        .o_count (w_hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_miss_inc),
        .o_count (w_miss_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_counter (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_wb_inc),
        .o_count (w_wb_cnt)
    );

    assign hit_count  = reset ? '0 : w_hit_cnt;
    assign miss_count = reset ? '0 : w_miss_cnt;
    assign wb_count   = reset ? '0 : w_wb_cnt;

endmodule
